mu0_run_ctrl: RTL and testbench

MU0_RUN_CTRL -- requirements
Module: mu0_run_ctrl

---
 rtl/mu0_pkg.sv | 21 ++
 rtl/mu0_cycle_counter.sv | 28 ++
 rtl/mu0_run_ctrl.sv | 134 +++++++++++++
 tb/tb_mu0_run_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared types and defaults for the MU0 load/run controller
package mu0_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4,
    ST_ABORT  = 3'd5
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_LOAD) || (s == ST_HOLD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/mu0_cycle_counter.sv
// rtl/mu0_cycle_counter.sv - run-cycle counter that saturates at the timeout limit
module mu0_cycle_counter
  import mu0_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/mu0_run_ctrl.sv
// rtl/mu0_run_ctrl.sv - loads a program into MU0 memory, releases reset and supervises the run
module mu0_run_ctrl
  import mu0_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              cpu_reset,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_ok;
  logic              accept;
  logic              last_word;
  logic              run_en;
  logic              at_limit;
  logic              cpu_reset_d;
  logic              busy_d;
  logic              done_d;
  logic              timed_out_d;

  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_FINISH) || (state == ST_ABORT));
  assign accept    = (state == ST_LOAD) && load_valid;
  // The top word of memory ends the load so the address counter never wraps.
  assign last_word = load_last || (addr_cnt == ADDR_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_FINISH, ST_ABORT: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept && last_word) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        // A halt seen on the timeout cycle still counts as a normal finish.
        if (cpu_halted) begin
          state_next = ST_FINISH;
        end else if (at_limit) begin
          state_next = ST_ABORT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    cpu_reset_d = !((state_next == ST_RUN) || (state_next == ST_FINISH));
    busy_d      = is_busy(state_next);
    done_d      = (state_next == ST_FINISH);
    timed_out_d = (state_next == ST_ABORT);
    run_en      = (state_next == ST_RUN);
  end

  assign load_ready = (state == ST_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_cnt  <= '0;
      hold_cnt  <= '0;
    end else begin
      cpu_reset <= cpu_reset_d;
      busy      <= busy_d;
      done      <= done_d;
      timed_out <= timed_out_d;
      mem_wen   <= accept;
      if (accept) begin
        mem_addr  <= addr_cnt;
        mem_wdata <= load_data;
        if (addr_cnt != ADDR_MAX) addr_cnt <= addr_cnt + ADDR_W'(1);
      end
      if (start_ok) addr_cnt <= '0;
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
    end
  end

  mu0_cycle_counter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_cycle_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .en      (run_en),
    .count   (cycle_count),
    .at_limit(at_limit)
  );

endmodule

// File: tb/tb_mu0_run_ctrl.sv
// tb/tb_mu0_run_ctrl.sv - self-checking bench for mu0_run_ctrl
module tb_mu0_run_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int RST   = 2;
  localparam int TO    = 50;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          cpu_reset;
  logic          cpu_halted;
  logic          busy;
  logic          done;
  logic          timed_out;
  logic [CW-1:0] cycle_count;

  int total = 0;
  int bad = 0;
  int wen_count = 0;
  logic [DW-1:0] prog[32];

  typedef struct {
    int n;
    int gap;
    int halt_at;
    int spam;
    int reset_at;
    int e_done;
    int e_to;
    int e_cnt;
    int e_cpurst;
    int e_nwr;
  } vec_t;

  vec_t tbl[8];

  mu0_run_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .RST_CYCLES(RST), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .cpu_reset(cpu_reset), .cpu_halted(cpu_halted), .busy(busy), .done(done),
    .timed_out(timed_out), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_wen) wen_count++;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int n, input int halt_at, output int d, output int t,
                                output int cnt, output int cr, output int nwr);
    nwr = (n < DEPTH) ? n : DEPTH;
    if (halt_at >= 1 && halt_at <= TO) begin
      d = 1; t = 0; cnt = halt_at; cr = 0;
    end else begin
      d = 0; t = 1; cnt = TO; cr = 1;
    end
  endfunction

  task automatic session(input int n, input int gap, input int halt_at, input int spam,
                         input int reset_at, input int e_done, input int e_to, input int e_cnt,
                         input int e_cpurst, input int e_nwr);
    int nw, idx, guard, end_k, wen_base;
    bit v, finish;
    nw = (n < DEPTH) ? n : DEPTH;
    cpu_halted = 0;
    start = 1;
    tick();
    start = 0;
    wen_base = wen_count;
    check("start_busy", busy, 1);
    check("start_ready", load_ready, 1);
    check("start_done", done, 0);
    check("start_to", timed_out, 0);
    check("start_cnt", cycle_count, 0);
    check("start_cpurst", cpu_reset, 1);

    idx = 0;
    guard = 0;
    while (idx < nw && guard < 400) begin
      case (gap)
        0:       v = 1;
        1:       v = (guard % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      load_valid = v;
      load_data  = prog[idx];
      load_last  = (idx == n - 1);
      start      = (spam != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      check("load_ready", load_ready, 1);
      tick();
      if (v) begin
        check("wr_wen", mem_wen, 1);
        check("wr_addr", mem_addr, idx);
        check("wr_data", mem_wdata, prog[idx]);
        idx++;
      end else begin
        check("gap_wen", mem_wen, 0);
      end
      guard++;
    end
    check("load_guard", idx, nw);
    load_valid = 0;
    load_last  = 0;

    for (int h = 0; h < RST; h++) begin
      check("hold_cpurst", cpu_reset, 1);
      check("hold_ready", load_ready, 0);
      check("hold_busy", busy, 1);
      start = (spam != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      start = 0;
    end

    finish = (halt_at >= 1 && halt_at <= TO);
    end_k  = finish ? halt_at : TO;
    if (reset_at >= 1 && reset_at <= end_k) begin
      end_k  = reset_at;
      finish = 0;
    end
    for (int k = 1; k <= end_k; k++) begin
      check("run_cnt", cycle_count, k);
      check("run_cpurst", cpu_reset, 0);
      check("run_busy", busy, 1);
      if (finish && k == halt_at) cpu_halted = 1;
      if (k == reset_at) reset = 1;
      start = (spam != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      start = 0;
      reset = 0;
    end

    check("end_done", done, e_done);
    check("end_to", timed_out, e_to);
    check("end_cnt", cycle_count, e_cnt);
    check("end_cpurst", cpu_reset, e_cpurst);
    check("end_busy", busy, 0);
    check("end_ready", load_ready, 0);
    if (reset_at != 0) begin
      check("rst_wen", mem_wen, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
    end
    repeat (3) tick();
    check("held_done", done, e_done);
    check("held_to", timed_out, e_to);
    check("held_cnt", cycle_count, e_cnt);
    check("held_cpurst", cpu_reset, e_cpurst);
    check("nwrites", wen_count - wen_base, e_nwr);
  endtask

  initial begin
    int d, t, cnt, cr, nwr, n, halt;
    clk = 0; reset = 1; start = 0; load_valid = 0; load_data = '0; load_last = 0;
    cpu_halted = 0;
    tick();
    tick();
    check("rv_cpurst", cpu_reset, 1);
    check("rv_wen", mem_wen, 0);
    check("rv_addr", mem_addr, 0);
    check("rv_wdata", mem_wdata, 0);
    check("rv_ready", load_ready, 0);
    check("rv_busy", busy, 0);
    check("rv_done", done, 0);
    check("rv_to", timed_out, 0);
    check("rv_cnt", cycle_count, 0);
    reset = 0;
    tick();
    check("idle_ready", load_ready, 0);
    check("idle_cpurst", cpu_reset, 1);

    // n, gap, halt_at, spam, reset_at | done, timed_out, count, cpu_reset, writes
    tbl[0] = '{3, 0, 34, 0, 0, 1, 0, 34, 0, 3};
    tbl[1] = '{3, 0, 0, 0, 0, 0, 1, 50, 1, 3};
    tbl[2] = '{6, 1, 5, 1, 0, 1, 0, 5, 0, 6};
    tbl[3] = '{2, 0, 50, 0, 0, 1, 0, 50, 0, 2};
    tbl[4] = '{20, 0, 1, 0, 0, 1, 0, 1, 0, 16};
    tbl[5] = '{4, 0, 0, 0, 10, 0, 0, 0, 1, 4};
    tbl[6] = '{16, 2, 49, 1, 0, 1, 0, 49, 0, 16};
    tbl[7] = '{1, 1, 2, 0, 0, 1, 0, 2, 0, 1};

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 32; j++) prog[j] = 16'($urandom);
      if (i == 0) begin
        prog[0] = 16'h1005;
        prog[1] = 16'h2006;
        prog[2] = 16'h7000;
      end
      session(tbl[i].n, tbl[i].gap, tbl[i].halt_at, tbl[i].spam, tbl[i].reset_at,
              tbl[i].e_done, tbl[i].e_to, tbl[i].e_cnt, tbl[i].e_cpurst, tbl[i].e_nwr);
    end

    // Reset landing on a cycle that accepts a word must suppress the write.
    start = 1;
    tick();
    start = 0;
    load_valid = 1;
    load_data  = 16'hABCD;
    reset      = 1;
    tick();
    reset = 0;
    load_valid = 0;
    check("ldrst_wen", mem_wen, 0);
    check("ldrst_addr", mem_addr, 0);
    check("ldrst_wdata", mem_wdata, 0);
    check("ldrst_busy", busy, 0);
    check("ldrst_ready", load_ready, 0);
    tick();
    check("ldrst_wen2", mem_wen, 0);

    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < 32; j++) prog[j] = 16'($urandom);
      n    = $urandom_range(1, 20);
      halt = $urandom_range(1, 60);
      model(n, halt, d, t, cnt, cr, nwr);
      session(n, $urandom_range(0, 2), halt, $urandom_range(0, 1), 0, d, t, cnt, cr, nwr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
